// File: rtl/mem_access_unit.sv
// Load/store front end between the memory stage and a word-wide data memory.
// Handles sub-word loads with extension, sub-word stores by read-modify-write.
`timescale 1ns/1ps
module mem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_misaligned,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] merged_q;
   logic        half_q;

   logic        f3_bad;
   logic        st_bad;
   logic        h_mis;
   logic        w_mis;
   logic        req_err;
   logic        accept;
   logic        is_sw;
   logic        is_rmw;
   logic [31:0] lane;
   logic [31:0] load_ext;
   logic [4:0]  rmw_sh;
   logic [31:0] rmw_mask;
   logic [31:0] merged_nx;

   always_comb begin
      f3_bad  = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
      st_bad  = req_write & req_funct3[2];
      h_mis   = (req_funct3[1:0] == 2'b01) & req_addr[0];
      w_mis   = (req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00);
      req_err = f3_bad | st_bad | h_mis | w_mis;
      accept  = req_valid & (state == IDLE);
      is_sw   = req_write & ~req_err & (req_funct3 == 3'b010);
      is_rmw  = req_write & ~req_err & (req_funct3 != 3'b010);
   end

   // Legal halfwords have addr[0]=0, so one byte-granular shift serves both widths.
   always_comb begin
      lane = mem_rdata >> {req_addr[1:0], 3'b000};
      unique case (req_funct3)
         3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
         3'b010:  load_ext = mem_rdata;
         3'b100:  load_ext = {24'd0, lane[7:0]};
         3'b101:  load_ext = {16'd0, lane[15:0]};
         default: load_ext = 32'd0;
      endcase
   end

   always_comb begin
      rmw_sh    = {addr_q[1:0], 3'b000};
      rmw_mask  = half_q ? 32'h0000_ffff : 32'h0000_00ff;
      merged_nx = (mem_rdata & ~(rmw_mask << rmw_sh))
                | ((wdata_q & rmw_mask) << rmw_sh);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept & is_rmw) state_nx = RD;
         RD:      state_nx = WR;
         WR:      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Gating with rst keeps the memory port quiet while reset is held.
   always_comb begin
      req_ready = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      unique case (1'b1)
         (state == IDLE): begin
            req_ready = rst;
            mem_we    = rst & req_valid & is_sw;
            mem_addr  = rst ? req_addr : 32'd0;
            mem_wdata = rst ? req_wdata : 32'd0;
         end
         (state == RD): begin
            mem_addr  = rst ? addr_q : 32'd0;
            mem_wdata = rst ? wdata_q : 32'd0;
         end
         (state == WR): begin
            mem_we    = rst;
            mem_addr  = rst ? addr_q : 32'd0;
            mem_wdata = rst ? merged_q : 32'd0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid      <= 1'b0;
         rsp_rdata      <= 32'd0;
         rsp_misaligned <= 1'b0;
         addr_q         <= 32'd0;
         wdata_q        <= 32'd0;
         merged_q       <= 32'd0;
         half_q         <= 1'b0;
      end else begin
         rsp_valid      <= 1'b0;
         rsp_rdata      <= 32'd0;
         rsp_misaligned <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  if (req_err) begin
                     rsp_valid      <= 1'b1;
                     rsp_misaligned <= 1'b1;
                  end else if (!req_write) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= load_ext;
                  end else if (is_sw) begin
                     rsp_valid <= 1'b1;
                  end else begin
                     addr_q  <= req_addr;
                     wdata_q <= req_wdata;
                     half_q  <= req_funct3[0];
                  end
               end
            end
            RD:      merged_q  <= merged_nx;
            WR:      rsp_valid <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level reference memory and response model,
// directed test-plan sequence, reset-abort cases and a randomized phase.
`timescale 1ns/1ps
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_misaligned;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_misaligned(rsp_misaligned),
      .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   logic [31:0] mem [0:255];
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

   logic [7:0] ref_b [0:1023];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic        mis;
      logic        has_lit;
      logic [31:0] lit;
   } rsp_t;

   typedef struct {
      int          due;
      logic [7:0]  widx;
      logic [31:0] data;
   } wr_t;

   rsp_t rq[$];
   wr_t  wq[$];

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] ref_word(input int a);
      return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
   endfunction

   // Transaction-level reference: decides legality from access size and
   // alignment, then updates the byte memory and schedules response/write.
   task automatic model(input bit w, input logic [2:0] f3, input int a,
                        input logic [31:0] d, input int c0,
                        input bit hl, input logic [31:0] lit);
      int size;
      bit legal;
      logic [63:0] v;
      rsp_t r;
      wr_t  x;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      legal = (size != 0) && !(w && f3 >= 3'd4) && (a % (size == 0 ? 1 : size) == 0);
      r.has_lit = hl;
      r.lit = lit;
      r.mis = 1'b0;
      r.data = 32'd0;
      r.due = c0;
      if (!legal) begin
         r.mis = 1'b1;
      end else if (!w) begin
         v = 64'd0;
         for (int i = 0; i < size; i++) v[8*i +: 8] = ref_b[a+i];
         if (!f3[2] && size < 4 && v[8*size-1])
            for (int i = 8*size; i < 32; i++) v[i] = 1'b1;
         r.data = v[31:0];
      end else begin
         for (int i = 0; i < size; i++) ref_b[a+i] = d[8*i +: 8];
         x.widx = 8'(a >> 2);
         x.data = ref_word(a & ~3);
         x.due  = (size == 4) ? c0 - 1 : c0 + 1;
         if (size != 4) r.due = c0 + 2;
         wq.push_back(x);
      end
      rq.push_back(r);
   endtask

   task automatic issue(input bit w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit use_model, input bit hl,
                        input logic [31:0] lit, output int waited);
      @(posedge clk);
      #2;
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = d;
      waited = 0;
      while (!req_ready && waited < 20) begin
         @(posedge clk);
         #2;
         waited++;
      end
      if (!req_ready) begin
         n_chk++;
         $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1",
                  req_ready, waited);
      end else if (use_model) begin
         model(w, f3, int'(a[9:0]), d, cyc + 1, hl, lit);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #2;
      req_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_rsp_mis"}, 32'(rsp_misaligned), 32'd0);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
   endtask

   always @(negedge clk) begin
      rsp_t e;
      wr_t  x;
      if (rst) begin
         if (rsp_valid) begin
            if (rq.size() == 0) begin
               chk("rsp_spurious", 32'(rsp_valid), 32'd0);
            end else begin
               e = rq.pop_front();
               chk("rsp_cycle", 32'(cyc), 32'(e.due));
               chk("rsp_misaligned", 32'(rsp_misaligned), 32'(e.mis));
               chk("rsp_rdata", rsp_rdata, e.data);
               if (e.has_lit) chk("rsp_literal", rsp_rdata, e.lit);
            end
         end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            e = rq.pop_front();
            chk("rsp_missing", 32'(rsp_valid), 32'd1);
         end
         if (mem_we) begin
            if (wq.size() == 0) begin
               chk("we_spurious", 32'(mem_we), 32'd0);
            end else begin
               x = wq.pop_front();
               chk("we_cycle", 32'(cyc), 32'(x.due));
               chk("we_addr", 32'(mem_addr[9:2]), 32'(x.widx));
               chk("we_data", mem_wdata, x.data);
            end
         end else if (wq.size() > 0 && wq[0].due <= cyc) begin
            x = wq.pop_front();
            chk("we_missing", 32'(mem_we), 32'd1);
         end
      end
   end

   initial begin
      int waited;
      int bad;
      logic [31:0] orig;
      logic [31:0] wv;
      logic [31:0] a;
      logic [2:0]  f3;
      bit          w;

      for (int i = 0; i < 256; i++) begin
         wv = (i == 'h40) ? 32'h8899aabb : $urandom;
         mem[i] = wv;
         for (int j = 0; j < 4; j++) ref_b[4*i+j] = wv[8*j +: 8];
      end
      #1;
      chk_reset_outputs("por");
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;

      issue(0, 3'b000, 32'h101, 0, 1, 1, 32'hffffffaa, waited);
      issue(0, 3'b100, 32'h101, 0, 1, 1, 32'h000000aa, waited);
      issue(0, 3'b001, 32'h102, 0, 1, 1, 32'hffff8899, waited);
      issue(0, 3'b101, 32'h102, 0, 1, 1, 32'h00008899, waited);
      issue(1, 3'b000, 32'h102, 32'h12345655, 1, 1, 32'd0, waited);
      issue(0, 3'b010, 32'h100, 0, 1, 1, 32'h8855aabb, waited);
      chk("sb_stall_cycles", 32'(waited), 32'd2);
      idle();
      chk("sb_word", mem[8'h40], 32'h8855aabb);
      issue(1, 3'b001, 32'h102, 32'h0000beef, 1, 1, 32'd0, waited);
      issue(0, 3'b010, 32'h100, 0, 1, 1, 32'hbeefaabb, waited);
      issue(1, 3'b010, 32'h104, 32'hcafef00d, 1, 1, 32'd0, waited);
      issue(0, 3'b010, 32'h104, 0, 1, 1, 32'hcafef00d, waited);
      issue(1, 3'b001, 32'h101, 32'h1111, 1, 1, 32'd0, waited);
      issue(0, 3'b010, 32'h102, 0, 1, 1, 32'd0, waited);
      issue(0, 3'b001, 32'h103, 0, 1, 1, 32'd0, waited);
      issue(0, 3'b011, 32'h100, 0, 1, 1, 32'd0, waited);
      idle();
      chk("err_word", mem[8'h40], 32'hbeefaabb);

      // Reset during RD of an sb: no write may reach memory.
      orig = ref_word('h100);
      issue(1, 3'b000, 32'h100, 32'h77, 0, 0, 32'd0, waited);
      @(posedge clk);
      #2;
      req_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk_reset_outputs("rst_rd");
      repeat (3) @(posedge clk);
      #2;
      chk("rst_rd_word", mem[8'h40], orig);
      rst = 1'b1;
      issue(0, 3'b010, 32'h100, 0, 1, 1, orig, waited);

      // Reset during WR of an sb.
      issue(1, 3'b000, 32'h100, 32'h66, 0, 0, 32'd0, waited);
      @(posedge clk);
      @(posedge clk);
      #2;
      req_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk_reset_outputs("rst_wr");
      repeat (3) @(posedge clk);
      #2;
      chk("rst_wr_word", mem[8'h40], orig);
      rst = 1'b1;
      issue(0, 3'b010, 32'h100, 0, 1, 1, orig, waited);

      for (int n = 0; n < 400; n++) begin
         w  = ($urandom % 3) == 0;
         f3 = 3'($urandom % 8);
         a  = $urandom_range(0, 1023);
         if (($urandom % 4) != 0) begin
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
         end
         if (($urandom % 5) == 0) idle();
         issue(w, f3, a, $urandom, 1, 0, 32'd0, waited);
      end
      idle();
      repeat (6) @(posedge clk);
      #2;
      chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
      chk("we_queue_drained", 32'(wq.size()), 32'd0);
      bad = 0;
      for (int i = 0; i < 256; i++)
         if (mem[i] !== ref_word(4*i)) bad++;
      chk("mem_image_mismatches", 32'(bad), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
